carrier_generator: RTL

Converts the controller's CTC interface (ctc_enable/ctc_forced/ctc_wr_strobe/ctc_value) into the square-wave IR carrier that drives the LED output stage. It sits directly downstream of the code-sequencing controller and replaces the AVR-style CTC timer of the original TV-B-Gone. Output toggles every (value+1) prescaled ticks, giving f_carrier = f_clk / (2 · PRESCALE · (value+1)).

---
 rtl/carrier_generator_if.sv | 36 +++
 rtl/carrier_generator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_generator_if.sv
`default_nettype none
// ============================================================================
// Module : carrier_generator_if
// Brief  : CTC control bus between the code-sequencing controller (master)
//          and the IR carrier generator (slave).
// Rev    : 1.0 - initial release
// ============================================================================
interface carrier_generator_if #(
    parameter int CTC_BITS = 8
);
    logic                ctc_enable_in;
    logic                ctc_forced_in;
    logic                ctc_wr_strobe_in;
    logic [CTC_BITS-1:0] ctc_value_in;
    logic                ir_out;
    logic                busy_out;

    modport master (
        output ctc_enable_in,
        output ctc_forced_in,
        output ctc_wr_strobe_in,
        output ctc_value_in,
        input  ir_out,
        input  busy_out
    );

    modport slave (
        input  ctc_enable_in,
        input  ctc_forced_in,
        input  ctc_wr_strobe_in,
        input  ctc_value_in,
        output ir_out,
        output busy_out
    );
endinterface : carrier_generator_if
`default_nettype wire

// File: rtl/carrier_generator.sv
`default_nettype none
// ============================================================================
// Module : carrier_generator
// Brief  : CTC-style square-wave IR carrier, f = f_clk / (2*PRESCALE*(V+1)).
//          Define CARRIER_GRACEFUL_STOP_EN to let a running high half-period
//          finish (DRAIN state) when enable falls.
// Rev    : 1.0 - initial release
// ============================================================================
module carrier_generator #(
    parameter int CTC_BITS = 8,
    parameter int PRESCALE = 1
) (
    input  wire                clock_in,
    input  wire                reset_n_in,
    carrier_generator_if.slave ctc_bus
);

    localparam int                  c_presc_w   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CTC_BITS-1:0] c_count_one = CTC_BITS'(1);
    localparam logic [c_presc_w-1:0] c_presc_one = c_presc_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FORCED = 2'd2
`ifdef CARRIER_GRACEFUL_STOP_EN
        ,
        ST_DRAIN  = 2'd3
`endif
    } state_t;

    state_t                r_state;
    logic [CTC_BITS-1:0]   r_shadow;
    logic [CTC_BITS-1:0]   r_active;
    logic [CTC_BITS-1:0]   r_count;
    logic [c_presc_w-1:0]  r_presc;
    logic                  r_phase;
    logic                  r_ir;

    state_t                w_state_nxt;
    logic [CTC_BITS-1:0]   w_shadow_nxt;
    logic [CTC_BITS-1:0]   w_active_nxt;
    logic [CTC_BITS-1:0]   w_count_nxt;
    logic [c_presc_w-1:0]  w_presc_nxt;
    logic                  w_phase_nxt;
    logic                  w_ir_nxt;

    logic                  w_tick;
    logic                  w_match;
    logic [CTC_BITS-1:0]   w_step_count;
    logic [c_presc_w-1:0]  w_step_presc;
    logic                  w_step_toggle;

    generate
        if (PRESCALE == 1) begin : g_tick_every
            assign w_tick = 1'b1;
        end else begin : g_tick_presc
            localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
            assign w_tick = (r_presc == c_presc_last);
        end
    endgenerate

    // Wrap is always via the compare, so count never overflows past active.
    assign w_match = (r_count == r_active);

    always_comb begin
        w_step_count  = r_count;
        w_step_presc  = r_presc + c_presc_one;
        w_step_toggle = 1'b0;
        if (w_tick) begin
            w_step_presc = '0;
            if (w_match) begin
                w_step_count  = '0;
                w_step_toggle = 1'b1;
            end else begin
                w_step_count  = r_count + c_count_one;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state  <= ST_IDLE;
            r_shadow <= '0;
            r_active <= '0;
            r_count  <= '0;
            r_presc  <= '0;
            r_phase  <= 1'b0;
            r_ir     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_shadow <= w_shadow_nxt;
            r_active <= w_active_nxt;
            r_count  <= w_count_nxt;
            r_presc  <= w_presc_nxt;
            r_phase  <= w_phase_nxt;
            r_ir     <= w_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_shadow_nxt = r_shadow;
        w_active_nxt = r_active;
        w_count_nxt  = r_count;
        w_presc_nxt  = r_presc;
        w_phase_nxt  = r_phase;
        w_ir_nxt     = r_ir;

        if (ctc_bus.ctc_wr_strobe_in) begin
            w_shadow_nxt = ctc_bus.ctc_value_in;
        end

        case (r_state)
            ST_IDLE: begin
                w_count_nxt = '0;
                w_presc_nxt = '0;
                w_phase_nxt = 1'b0;
                w_ir_nxt    = 1'b0;
                if (ctc_bus.ctc_wr_strobe_in) begin
                    w_active_nxt = ctc_bus.ctc_value_in;
                end
                if (ctc_bus.ctc_forced_in) begin
                    w_state_nxt = ST_FORCED;
                    w_ir_nxt    = 1'b1;
                end else if (ctc_bus.ctc_enable_in) begin
                    // Starting a burst is a period boundary; a same-edge write wins.
                    w_state_nxt  = ST_RUN;
                    w_phase_nxt  = 1'b1;
                    w_ir_nxt     = 1'b1;
                    w_active_nxt = ctc_bus.ctc_wr_strobe_in ? ctc_bus.ctc_value_in : r_shadow;
                end
            end

            ST_RUN: begin
                if (ctc_bus.ctc_forced_in) begin
                    w_state_nxt = ST_FORCED;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                    w_ir_nxt    = 1'b1;
                end else if (!ctc_bus.ctc_enable_in) begin
`ifdef CARRIER_GRACEFUL_STOP_EN
                    if (r_phase && !w_step_toggle) begin
                        w_state_nxt = ST_DRAIN;
                        w_count_nxt = w_step_count;
                        w_presc_nxt = w_step_presc;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = '0;
                        w_presc_nxt = '0;
                        w_phase_nxt = 1'b0;
                        w_ir_nxt    = 1'b0;
                    end
`else
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                    w_phase_nxt = 1'b0;
                    w_ir_nxt    = 1'b0;
`endif
                end else begin
                    w_count_nxt = w_step_count;
                    w_presc_nxt = w_step_presc;
                    if (w_step_toggle) begin
                        w_phase_nxt = ~r_phase;
                        w_ir_nxt    = ~r_phase;
                        // Low->high toggle: pick up the pending value (old shadow on a same-edge write).
                        if (!r_phase) begin
                            w_active_nxt = r_shadow;
                        end
                    end
                end
            end

            ST_FORCED: begin
                w_count_nxt = '0;
                w_presc_nxt = '0;
                w_ir_nxt    = 1'b1;
                if (!ctc_bus.ctc_forced_in) begin
                    if (ctc_bus.ctc_enable_in) begin
                        w_state_nxt  = ST_RUN;
                        w_phase_nxt  = 1'b1;
                        w_active_nxt = r_shadow;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_phase_nxt = 1'b0;
                        w_ir_nxt    = 1'b0;
                    end
                end
            end

`ifdef CARRIER_GRACEFUL_STOP_EN
            ST_DRAIN: begin
                if (ctc_bus.ctc_forced_in) begin
                    w_state_nxt = ST_FORCED;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                    w_ir_nxt    = 1'b1;
                end else if (ctc_bus.ctc_enable_in) begin
                    // Output is already high; rejoin the burst without a glitch.
                    w_state_nxt = ST_RUN;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                    w_phase_nxt = 1'b1;
                    w_ir_nxt    = 1'b1;
                end else if (w_step_toggle) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_presc_nxt = '0;
                    w_phase_nxt = 1'b0;
                    w_ir_nxt    = 1'b0;
                end else begin
                    w_count_nxt = w_step_count;
                    w_presc_nxt = w_step_presc;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_IDLE;
                w_count_nxt = '0;
                w_presc_nxt = '0;
                w_phase_nxt = 1'b0;
                w_ir_nxt    = 1'b0;
            end
        endcase
    end

    assign ctc_bus.ir_out   = r_ir;
    assign ctc_bus.busy_out = (r_state != ST_IDLE);

endmodule : carrier_generator
`default_nettype wire
